// File: rtl/insn_fetch_sequencer.sv
// insn_fetch_sequencer: pulls one instruction at a time from the prefetch FIFO
// (opcode, optional ModR/M handled by an external decoder, then immediate bytes)
// and hands the opcode plus assembled immediate to the microcode core.
//
// Ports:
//   clk, reset            clock; asynchronous active-high reset
//   flush                 synchronous abandon of the current instruction
//   fifo_rd_en            FIFO pop (muxed to the ModR/M decoder while it runs)
//   fifo_rd_data          FIFO byte, valid the cycle after a pop
//   fifo_empty            FIFO empty
//   opcode                latched opcode, feeds the opcode table
//   has_modrm, imm_bytes  opcode table results (imm_bytes 3 acts as 2)
//   modrm_start           one-cycle decoder start pulse
//   modrm_fifo_rd_en      decoder's FIFO pop request
//   modrm_complete        decoder done
//   insn_valid/ready      handshake to the microcode core
//   insn_has_modrm        latched has_modrm
//   insn_immediate        assembled 16-bit immediate
module insn_fetch_sequencer #(
    parameter bit SEXT_IMM8 = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        flush,
    output logic        fifo_rd_en,
    input  logic [7:0]  fifo_rd_data,
    input  logic        fifo_empty,
    output logic [7:0]  opcode,
    input  logic        has_modrm,
    input  logic [1:0]  imm_bytes,
    output logic        modrm_start,
    input  logic        modrm_fifo_rd_en,
    input  logic        modrm_complete,
    output logic        insn_valid,
    input  logic        insn_ready,
    output logic        insn_has_modrm,
    output logic [15:0] insn_immediate
);
    typedef enum logic [2:0] {FETCH_OP, WAIT_OP, DISPATCH, MODRM, IMM, VALID} state_t;

    state_t     state;
    logic       live;
    logic       pend;
    logic [1:0] issued;
    logic [1:0] received;
    logic [1:0] n;
    logic [1:0] imm_len;
    logic       seq_pop;
    logic       lend;
    logic [7:0] ext;

    assign imm_len = (imm_bytes == 2'd3) ? 2'd2 : imm_bytes;
    assign ext     = SEXT_IMM8 ? {8{fifo_rd_data[7]}} : 8'h00;

    // live is low while reset is held and for the first cycle after release,
    // keeping the pop deasserted during reset without using reset as data.
    assign seq_pop = live & ~flush & ~fifo_empty &
                     ((state == FETCH_OP) | ((state == IMM) & (issued < n)));

    // The decoder owns the read port from its start cycle until it completes.
    assign lend        = ~flush & (((state == DISPATCH) & has_modrm) | (state == MODRM));
    assign fifo_rd_en  = lend ? modrm_fifo_rd_en : seq_pop;
    assign modrm_start = ~flush & (state == DISPATCH) & has_modrm;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state          <= FETCH_OP;
            live           <= 1'b0;
            pend           <= 1'b0;
            issued         <= 2'd0;
            received       <= 2'd0;
            n              <= 2'd0;
            opcode         <= 8'h00;
            insn_immediate <= 16'h0000;
            insn_has_modrm <= 1'b0;
            insn_valid     <= 1'b0;
        end else begin
            live <= 1'b1;
            if (flush) begin
                state          <= FETCH_OP;
                pend           <= 1'b0;
                issued         <= 2'd0;
                received       <= 2'd0;
                n              <= 2'd0;
                opcode         <= 8'h00;
                insn_immediate <= 16'h0000;
                insn_has_modrm <= 1'b0;
                insn_valid     <= 1'b0;
            end else begin
                case (state)
                    FETCH_OP: if (seq_pop) state <= WAIT_OP;
                    WAIT_OP: begin
                        opcode         <= fifo_rd_data;
                        insn_immediate <= 16'h0000;
                        pend           <= 1'b0;
                        issued         <= 2'd0;
                        received       <= 2'd0;
                        state          <= DISPATCH;
                    end
                    DISPATCH: begin
                        insn_has_modrm <= has_modrm;
                        n              <= imm_len;
                        if (has_modrm) begin
                            state <= MODRM;
                        end else if (imm_len != 2'd0) begin
                            state <= IMM;
                        end else begin
                            state      <= VALID;
                            insn_valid <= 1'b1;
                        end
                    end
                    MODRM: begin
                        if (modrm_complete) begin
                            if (n != 2'd0) begin
                                state <= IMM;
                            end else begin
                                state      <= VALID;
                                insn_valid <= 1'b1;
                            end
                        end
                    end
                    IMM: begin
                        pend <= seq_pop;
                        if (seq_pop) issued <= issued + 2'd1;
                        // pend marks the byte popped last cycle, now on fifo_rd_data.
                        if (pend) begin
                            received <= received + 2'd1;
                            if (received == 2'd0)
                                insn_immediate <= {(n == 2'd1) ? ext : 8'h00, fifo_rd_data};
                            else
                                insn_immediate[15:8] <= fifo_rd_data;
                            if (received + 2'd1 == n) begin
                                state      <= VALID;
                                insn_valid <= 1'b1;
                            end
                        end
                    end
                    VALID: begin
                        if (insn_ready) begin
                            state      <= FETCH_OP;
                            insn_valid <= 1'b0;
                        end
                    end
                    default: state <= FETCH_OP;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_insn_fetch_sequencer.sv
// tb_insn_fetch_sequencer: scoreboard bench with FIFO, opcode-table and ModR/M decoder models.
module tb_insn_fetch_sequencer;
    logic        clk = 1'b0;
    logic        reset, flush, insn_ready;
    logic        fifo_rd_en, fifo_rd_en1;
    logic [7:0]  fifo_rd_data;
    logic        fifo_empty;
    logic [7:0]  opcode, opcode1;
    logic        has_modrm;
    logic [1:0]  imm_bytes;
    logic        modrm_start, modrm_start1;
    logic        modrm_fifo_rd_en, modrm_complete;
    logic        insn_valid, insn_valid1;
    logic        insn_has_modrm, insn_has_modrm1;
    logic [15:0] insn_immediate, insn_immediate1;

    typedef struct packed {
        logic [7:0]  op;
        logic        hm;
        logic [15:0] imm;
    } exp_t;

    exp_t       sb[$];
    int         checks = 0;
    int         failures = 0;
    logic [7:0] mem[64];
    int         wp = 0;
    int         rp = 0;
    int         underflow = 0;
    int         starts = 0;
    logic       starve, tbl_modrm, dec_force;
    logic [1:0] tbl_imm;
    int         dn;
    logic       dec_busy, dec_pend;
    int         dec_iss, dec_rcv;
    logic [7:0] dec_b[4];

    always #5 clk = ~clk;

    insn_fetch_sequencer #(.SEXT_IMM8(1'b1)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .fifo_rd_en(fifo_rd_en), .fifo_rd_data(fifo_rd_data), .fifo_empty(fifo_empty),
        .opcode(opcode), .has_modrm(has_modrm), .imm_bytes(imm_bytes),
        .modrm_start(modrm_start), .modrm_fifo_rd_en(modrm_fifo_rd_en),
        .modrm_complete(modrm_complete), .insn_valid(insn_valid), .insn_ready(insn_ready),
        .insn_has_modrm(insn_has_modrm), .insn_immediate(insn_immediate)
    );

    // Zero-extending variant run in lockstep on the same inputs.
    insn_fetch_sequencer #(.SEXT_IMM8(1'b0)) dut1 (
        .clk(clk), .reset(reset), .flush(flush),
        .fifo_rd_en(fifo_rd_en1), .fifo_rd_data(fifo_rd_data), .fifo_empty(fifo_empty),
        .opcode(opcode1), .has_modrm(has_modrm), .imm_bytes(imm_bytes),
        .modrm_start(modrm_start1), .modrm_fifo_rd_en(modrm_fifo_rd_en),
        .modrm_complete(modrm_complete), .insn_valid(insn_valid1), .insn_ready(insn_ready),
        .insn_has_modrm(insn_has_modrm1), .insn_immediate(insn_immediate1)
    );

    assign fifo_empty = starve || (wp == rp);
    assign has_modrm  = tbl_modrm;
    assign imm_bytes  = tbl_imm;

    always @(posedge clk) begin
        if (fifo_rd_en) begin
            if (wp != rp) begin
                fifo_rd_data <= mem[rp];
                rp <= rp + 1;
            end else begin
                underflow <= underflow + 1;
            end
        end
    end

    assign modrm_fifo_rd_en = dec_force | ((modrm_start | dec_busy) & (dec_iss < dn) & ~fifo_empty);
    assign modrm_complete   = dec_busy & dec_pend & (dec_rcv + 1 == dn);

    always @(posedge clk or posedge reset) begin
        if (reset || flush) begin
            dec_busy <= 1'b0;
            dec_pend <= 1'b0;
            dec_iss  <= 0;
            dec_rcv  <= 0;
        end else begin
            if (modrm_start) dec_busy <= 1'b1;
            if (modrm_fifo_rd_en && !dec_force) dec_iss <= dec_iss + 1;
            dec_pend <= modrm_fifo_rd_en & ~dec_force;
            if (dec_pend) begin
                dec_b[dec_rcv[1:0]] <= fifo_rd_data;
                dec_rcv <= dec_rcv + 1;
            end
            if (modrm_complete) begin
                dec_busy <= 1'b0;
                dec_iss  <= 0;
                dec_rcv  <= 0;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (modrm_start) starts <= starts + 1;
        if (!reset && !flush && insn_valid && insn_ready) begin
            if (sb.size() == 0) begin
                check("sb_underrun", 1, 0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("sb_opcode", opcode, e.op);
                check("sb_has_modrm", insn_has_modrm, e.hm);
                check("sb_immediate", insn_immediate, e.imm);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] b);
        mem[wp] = b;
        wp++;
    endtask

    task automatic wait_valid(input string tag, output int fp, output int at);
        fp = -1;
        at = -1;
        for (int i = 0; i < 60; i++) begin
            if (fifo_rd_en && fp < 0) fp = i;
            if (insn_valid) begin
                at = i;
                break;
            end
            step();
        end
        if (at < 0) check({tag, "_timeout"}, 0, 1);
    endtask

    task automatic handshake(input string tag);
        insn_ready = 1'b1;
        step();
        insn_ready = 1'b0;
        check({tag, "_valid_drop"}, insn_valid, 0);
    endtask

    task automatic wait_pops(input string tag, input int base, input int cnt);
        int ok = 0;
        for (int i = 0; i < 40; i++) begin
            if (rp - base >= cnt) begin
                ok = 1;
                break;
            end
            step();
        end
        if (ok == 0) check({tag, "_timeout"}, 0, 1);
    endtask

    initial begin
        int fp, at, p0, s0;
        reset = 1'b1; flush = 1'b0; insn_ready = 1'b0; starve = 1'b0;
        tbl_modrm = 1'b0; tbl_imm = 2'd0; dn = 0; dec_force = 1'b0;
        push(8'h90);
        repeat (3) step();
        check("rst_rd_en", fifo_rd_en, 0);
        check("rst_valid", insn_valid, 0);
        check("rst_opcode", opcode, 0);
        check("rst_imm", insn_immediate, 0);
        check("rst_start", modrm_start, 0);
        reset = 1'b0;

        // Opcode only
        p0 = rp;
        sb.push_back({8'h90, 1'b0, 16'h0000});
        wait_valid("op_only", fp, at);
        check("op_only_latency", at - fp, 3);
        check("op_only_opcode", opcode, 8'h90);
        check("op_only_imm", insn_immediate, 16'h0000);
        handshake("op_only");
        check("op_only_pops", rp - p0, 1);

        // ModR/M + imm16
        tbl_modrm = 1'b1; tbl_imm = 2'd2; dn = 2;
        p0 = rp; s0 = starts;
        sb.push_back({8'h81, 1'b1, 16'h1234});
        push(8'h81); push(8'h80); push(8'h10); push(8'h34); push(8'h12);
        #1;
        wait_valid("modrm16", fp, at);
        check("modrm16_starts", starts - s0, 1);
        check("modrm16_dec0", dec_b[0], 8'h80);
        check("modrm16_dec1", dec_b[1], 8'h10);
        check("modrm16_imm", insn_immediate, 16'h1234);
        check("modrm16_pops", rp - p0, 5);
        handshake("modrm16");

        // imm8 extension
        tbl_modrm = 1'b1; tbl_imm = 2'd1; dn = 1;
        sb.push_back({8'h83, 1'b1, 16'hFFFE});
        push(8'h83); push(8'hC0); push(8'hFE);
        #1;
        wait_valid("imm8", fp, at);
        check("imm8_dec0", dec_b[0], 8'hC0);
        check("imm8_zext", insn_immediate1, 16'h00FE);
        check("imm8_sext", insn_immediate, 16'hFFFE);
        handshake("imm8");

        // Starvation between immediate bytes, imm_bytes=3 acting as 2
        tbl_modrm = 1'b0; tbl_imm = 2'd3; dn = 0;
        p0 = rp;
        sb.push_back({8'hB8, 1'b0, 16'hBEEF});
        push(8'hB8); push(8'hEF); push(8'hBE);
        #1;
        wait_pops("starve", p0, 2);
        starve = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            check("starve_rd_en", fifo_rd_en, 0);
            check("starve_pops", rp - p0, 2);
            check("starve_valid", insn_valid, 0);
        end
        starve = 1'b0;
        wait_valid("starve", fp, at);
        check("starve_imm", insn_immediate, 16'hBEEF);
        check("starve_total_pops", rp - p0, 3);
        handshake("starve");

        // Backpressure, then flush colliding with ready
        tbl_modrm = 1'b0; tbl_imm = 2'd0;
        push(8'h40);
        #1;
        wait_valid("bp", fp, at);
        push(8'h41);
        for (int i = 0; i < 4; i++) begin
            #1;
            check("bp_valid", insn_valid, 1);
            check("bp_opcode", opcode, 8'h40);
            check("bp_no_pop", fifo_rd_en, 0);
            step();
        end
        sb.push_back({8'h41, 1'b0, 16'h0000});
        flush = 1'b1; insn_ready = 1'b1;
        #1;
        check("flush_rd_en", fifo_rd_en, 0);
        step();
        flush = 1'b0; insn_ready = 1'b0;
        check("flush_valid", insn_valid, 0);
        check("flush_opcode", opcode, 0);
        #1;
        check("flush_refetch", fifo_rd_en, 1);
        wait_valid("after_flush", fp, at);
        check("after_flush_opcode", opcode, 8'h41);
        handshake("after_flush");

        // Flush while the decoder is starved in MODRM
        tbl_modrm = 1'b1; tbl_imm = 2'd0; dn = 3;
        s0 = starts;
        push(8'hC7); push(8'h05);
        #1;
        for (int i = 0; i < 20 && starts == s0; i++) step();
        check("mflush_started", starts - s0, 1);
        repeat (3) step();
        check("mflush_wait", insn_valid, 0);
        dec_force = 1'b1; flush = 1'b1;
        #1;
        check("mflush_rd_en", fifo_rd_en, 0);
        step();
        flush = 1'b0;
        check("mflush_ignored", fifo_rd_en, 0);
        check("mflush_opcode", opcode, 0);
        dec_force = 1'b0;

        // Async reset mid-IMM
        tbl_modrm = 1'b1; tbl_imm = 2'd2; dn = 1;
        p0 = rp;
        push(8'h99); push(8'hD0); push(8'h11); push(8'h22);
        #1;
        wait_pops("rst_imm", p0, 3);
        step();
        check("pre_rst_opcode", opcode, 8'h99);
        check("pre_rst_imm", insn_immediate, 16'h0011);
        check("pre_rst_hm", insn_has_modrm, 1);
        #2 reset = 1'b1;
        #1;
        check("arst_rd_en", fifo_rd_en, 0);
        check("arst_start", modrm_start, 0);
        check("arst_valid", insn_valid, 0);
        check("arst_opcode", opcode, 0);
        check("arst_imm", insn_immediate, 0);
        check("arst_hm", insn_has_modrm, 0);
        repeat (2) step();
        reset = 1'b0;
        step();

        check("fifo_underflow", underflow, 0);
        check("sb_leftover", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/insn_fetch_sequencer.md
Name: insn_fetch_sequencer

Overview:
- Owns the instruction prefetch FIFO read port and sequences one instruction at a time: opcode byte, optional ModR/M plus displacement, then immediate bytes.
- Drives the opcode to the external combinational opcode table. Starts the ModR/M decoder and lends it the FIFO read port while it runs.
- Presents the assembled opcode and immediate to the microcode core over a valid/ready handshake.

Parameters:
- SEXT_IMM8, 1: 1 = a 1-byte immediate is sign-extended to 16 bits; 0 = zero-extended.

Ports:
- clk  in  1  clock
- reset  in  1  reset, asynchronous, active-high
- flush  in  1  synchronous abandon of current instruction (jump/interrupt)
- fifo_rd_en  out  1  prefetch FIFO pop
- fifo_rd_data  in  8  FIFO data, valid the cycle after a pop
- fifo_empty  in  1  FIFO empty
- opcode  out  8  latched opcode, to opcode table
- has_modrm  in  1  table: opcode carries ModR/M
- imm_bytes  in  2  table: immediate length 0/1/2 (3 treated as 2)
- modrm_start  out  1  one-cycle start pulse to ModR/M decoder
- modrm_fifo_rd_en  in  1  decoder's FIFO pop request
- modrm_complete  in  1  decoder done (combinational, same cycle as its last byte)
- insn_valid  out  1  instruction ready for core
- insn_ready  in  1  core accepts
- insn_has_modrm  out  1  latched has_modrm
- insn_immediate  out  16  assembled immediate

Behaviour:
- States: FETCH_OP, WAIT_OP, DISPATCH, MODRM, IMM, VALID.
- Reset and flush values: state FETCH_OP; fifo_rd_en, modrm_start, insn_valid = 0; opcode, insn_immediate = 0; insn_has_modrm = 0; byte counters = 0.
- FETCH_OP:
  - fifo_rd_en = ~fifo_empty.
  - On pop, go to WAIT_OP; otherwise stay.
- WAIT_OP:
  - opcode <= fifo_rd_data; insn_immediate <= 0; go to DISPATCH.
- DISPATCH:
  - Sample has_modrm/imm_bytes and latch insn_has_modrm.
  - If has_modrm: assert modrm_start for this cycle only, then MODRM.
  - Else if imm_bytes != 0: IMM.
  - Else: VALID.
  - Minimum opcode-only latency: pop at cycle N, insn_valid at N+3.
- FIFO port mux: in DISPATCH with has_modrm=1, and throughout MODRM, fifo_rd_en = modrm_fifo_rd_en. In all other states the sequencer drives it, and modrm_fifo_rd_en is ignored.
- MODRM:
  - Wait for modrm_complete.
  - On complete: imm_bytes != 0 -> IMM, else VALID.
  - modrm_complete outside MODRM is ignored.
- IMM:
  - issued counter: fifo_rd_en = ~fifo_empty & (issued < imm_bytes).
  - Each pop's data is captured the following cycle: received==0 -> [7:0], received==1 -> [15:8].
  - If imm_bytes==1, [15:8] = sign/zero extension of the byte per SEXT_IMM8, written in the same cycle.
  - When received reaches imm_bytes, go to VALID. FIFO empty stalls issue without losing count.
- VALID:
  - insn_valid=1; opcode, insn_immediate, insn_has_modrm held stable.
  - On insn_valid & insn_ready: go to FETCH_OP, insn_valid=0 next cycle.
  - No pops while in VALID (no pipelining of the next opcode).
- flush:
  - Highest priority over every state, including the VALID handshake cycle.
  - Next state FETCH_OP. fifo_rd_en forced 0 in the flush cycle. Any in-flight popped byte is discarded. Counters cleared.
- reset mid-operation: asynchronous return to reset values. Output modrm_start is cleared immediately.
- Width rules: issued/received are 2-bit counters, saturating at 2. imm_bytes=3 behaves exactly as 2.

Test Plan:
- Opcode-only: FIFO holds 0x90; has_modrm=0, imm_bytes=0 -> one pop; insn_valid 3 cycles after pop with opcode=0x90, immediate 0x0000; ready=1 -> back to FETCH_OP.
- ModR/M + imm16: FIFO 0x81,0x80,0x10,0x34,0x12 with has_modrm=1, imm_bytes=2 -> modrm_start pulses once; decoder pops 0x80,0x10 via the muxed port; sequencer pops 0x34,0x12; insn_immediate=0x1234.
- imm8 sign-extend: FIFO 0x83,0xC0,0xFE with SEXT_IMM8=1 -> insn_immediate=0xFFFE. With SEXT_IMM8=0 -> 0x00FE.
- FIFO starvation: fifo_empty asserted between immediate bytes for 5 cycles -> no extra pops, counters hold, correct 0xBEEF assembled after refill.
- Backpressure and flush: insn_ready held 0 for 4 cycles -> outputs stable. Then flush with ready=1 in the same cycle -> no handshake, insn_valid=0 next cycle, state FETCH_OP.
- Flush in MODRM, then reset mid-IMM: flush -> decoder's rd requests ignored, state FETCH_OP. Async reset mid-IMM -> all outputs 0 immediately.
